// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch stage: RV32I major opcodes,
// fetch FSM states, predictor counter init, and immediate extraction helpers.
package inst_fetcher_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] CTR_INIT  = 2'b01;

   typedef enum logic [1:0] {
      FETCH,
      WAIT_MEM,
      STALL_JALR,
      DISCARD
   } fetch_state_e;

   // J-type immediate from inst[31:12], sign-extended to 32 bits
   function automatic logic [31:0] imm_j(input logic [19:0] hi);
      return {{12{hi[19]}}, hi[7:0], hi[8], hi[18:9], 1'b0};
   endfunction

   // B-type immediate from funct7 field (inst[31:25]) and rd field (inst[11:7])
   function automatic logic [31:0] imm_b(input logic [6:0] f7, input logic [4:0] f5);
      return {{20{f7[6]}}, f5[0], f7[5:0], f5[4:1], 1'b0};
   endfunction

endpackage

// File: rtl/inst_fetcher_branch_predictor.sv
// Bimodal branch predictor: table of 2-bit saturating counters with an
// asynchronous lookup port and a clocked training port. Used when IF_BHT_EN is set.
module branch_predictor
   import inst_fetcher_pkg::*;
#(
   parameter int unsigned BHT_SIZE_LOG = 6
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic [BHT_SIZE_LOG-1:0] lookup_idx,
   output logic                    taken_c,
   input  logic                    update_en,
   input  logic [BHT_SIZE_LOG-1:0] update_idx,
   input  logic                    update_taken
);

   localparam int unsigned ENTRIES = 1 << BHT_SIZE_LOG;

   logic [1:0] ctr_q [ENTRIES];

   // Lookup reads the stored value, so a same-cycle update is not visible yet
   assign taken_c = ctr_q[lookup_idx][1];

   // Counter training with saturation at both ends
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            ctr_q[BHT_SIZE_LOG'(i)] <= CTR_INIT;
         end
      end else if (rdy_in && update_en) begin
         if (update_taken) begin
            if (ctr_q[update_idx] != 2'b11) ctr_q[update_idx] <= ctr_q[update_idx] + 2'd1;
         end else begin
            if (ctr_q[update_idx] != 2'b00) ctr_q[update_idx] <= ctr_q[update_idx] - 2'd1;
         end
      end
   end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: owns the fetch PC, issues one icache request at a
// time, hands each word to the decoder with a direction prediction, redirects
// on ROB flush and stalls on jalr. Define IF_BHT_EN to enable the bimodal
// predictor; otherwise branches are predicted not-taken.
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH   = 32,
   parameter int unsigned            BHT_SIZE_LOG = 6,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC     = '0
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   output logic                  IFIC_en,
   output logic [ADDR_WIDTH-1:0] IFIC_addr,
   input  logic                  ICIF_en,
   input  logic [31:0]           ICIF_inst,
   output logic                  IFDC_en,
   output logic [ADDR_WIDTH-1:0] IFDC_pc,
   output logic [6:0]            IFDC_opcode,
   output logic [24:0]           IFDC_remain_inst,
   output logic                  IFDC_predict_result,
   input  logic                  DCIF_ask_IF,
   input  logic                  ROBIF_flush,
   input  logic [ADDR_WIDTH-1:0] ROBIF_new_pc,
   input  logic                  ROBIF_jalr_en,
   input  logic [ADDR_WIDTH-1:0] ROBIF_jalr_pc,
   input  logic                  ROBIF_br_en,
   input  logic [ADDR_WIDTH-1:0] ROBIF_br_pc,
   input  logic                  ROBIF_br_taken
);

   fetch_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic                    ific_en_d;
   logic [ADDR_WIDTH-1:0]   ific_addr_d;
   logic                    ifdc_en_d;
   logic [ADDR_WIDTH-1:0]   ifdc_pc_d;
   logic [6:0]              ifdc_opcode_d;
   logic [24:0]             ifdc_remain_d;
   logic                    ifdc_pred_d;
   logic                    bht_taken_c;

`ifdef IF_BHT_EN
   logic unused_br_pc;
   assign unused_br_pc = ^{ROBIF_br_pc[ADDR_WIDTH-1:BHT_SIZE_LOG+2], ROBIF_br_pc[1:0]};

   branch_predictor #(.BHT_SIZE_LOG(BHT_SIZE_LOG)) u_branch_predictor (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .lookup_idx   (pc_q[BHT_SIZE_LOG+1:2]),
      .taken_c      (bht_taken_c),
      .update_en    (ROBIF_br_en),
      .update_idx   (ROBIF_br_pc[BHT_SIZE_LOG+1:2]),
      .update_taken (ROBIF_br_taken)
   );
`else
   logic unused_br;
   assign unused_br   = ^{ROBIF_br_en, ROBIF_br_pc, ROBIF_br_taken};
   assign bht_taken_c = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // Next-state, next-PC and next-output decode
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ific_en_d     = 1'b0;
      ific_addr_d   = IFIC_addr;
      ifdc_en_d     = 1'b0;
      ifdc_pc_d     = IFDC_pc;
      ifdc_opcode_d = IFDC_opcode;
      ifdc_remain_d = IFDC_remain_inst;
      ifdc_pred_d   = IFDC_predict_result;
      if (rdy_in) begin
         if (ROBIF_flush) begin
            pc_d = ROBIF_new_pc;
            case (state_q)
               WAIT_MEM: state_d = ICIF_en ? FETCH : DISCARD;
               DISCARD:  state_d = ICIF_en ? FETCH : DISCARD;
               default:  state_d = FETCH;
            endcase
         end else begin
            case (state_q)
               FETCH: begin
                  if (DCIF_ask_IF) begin
                     ific_en_d   = 1'b1;
                     ific_addr_d = pc_q;
                     state_d     = WAIT_MEM;
                  end
               end
               WAIT_MEM: begin
                  if (ICIF_en) begin
                     ifdc_en_d     = 1'b1;
                     ifdc_pc_d     = pc_q;
                     ifdc_opcode_d = ICIF_inst[6:0];
                     ifdc_remain_d = ICIF_inst[31:7];
                     ifdc_pred_d   = 1'b0;
                     pc_d          = pc_q + ADDR_WIDTH'(32'd4);
                     state_d       = FETCH;
                     case (ICIF_inst[6:0])
                        OP_JAL: begin
                           pc_d        = pc_q + ADDR_WIDTH'($signed(imm_j(ICIF_inst[31:12])));
                           ifdc_pred_d = 1'b1;
                        end
                        OP_JALR: begin
                           pc_d    = pc_q;
                           state_d = STALL_JALR;
                        end
                        OP_BRANCH: begin
                           if (bht_taken_c) begin
                              pc_d        = pc_q + ADDR_WIDTH'($signed(imm_b(ICIF_inst[31:25], ICIF_inst[11:7])));
                              ifdc_pred_d = 1'b1;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
               STALL_JALR: begin
                  if (ROBIF_jalr_en) begin
                     pc_d    = ROBIF_jalr_pc;
                     state_d = FETCH;
                  end
               end
               DISCARD: begin
                  if (ICIF_en) state_d = FETCH;
               end
               default: state_d = FETCH;
            endcase
         end
      end
   end

   // PC and registered outputs
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pc_q                <= RESET_PC;
         IFIC_en             <= 1'b0;
         IFIC_addr           <= RESET_PC;
         IFDC_en             <= 1'b0;
         IFDC_pc             <= '0;
         IFDC_opcode         <= '0;
         IFDC_remain_inst    <= '0;
         IFDC_predict_result <= 1'b0;
      end else begin
         pc_q                <= pc_d;
         IFIC_en             <= ific_en_d;
         IFIC_addr           <= ific_addr_d;
         IFDC_en             <= ifdc_en_d;
         IFDC_pc             <= ifdc_pc_d;
         IFDC_opcode         <= ifdc_opcode_d;
         IFDC_remain_inst    <= ifdc_remain_d;
         IFDC_predict_result <= ifdc_pred_d;
      end
   end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed self-checking bench for inst_fetcher: a table of sequential fetch
// transactions followed by hand-written redirect, stall and pause sequences.
module tb_inst_fetcher;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        IFIC_en;
   logic [31:0] IFIC_addr;
   logic        ICIF_en;
   logic [31:0] ICIF_inst;
   logic        IFDC_en;
   logic [31:0] IFDC_pc;
   logic [6:0]  IFDC_opcode;
   logic [24:0] IFDC_remain_inst;
   logic        IFDC_predict_result;
   logic        DCIF_ask_IF;
   logic        ROBIF_flush;
   logic [31:0] ROBIF_new_pc;
   logic        ROBIF_jalr_en;
   logic [31:0] ROBIF_jalr_pc;
   logic        ROBIF_br_en;
   logic [31:0] ROBIF_br_pc;
   logic        ROBIF_br_taken;

   int n_cmp  = 0;
   int n_fail = 0;

   inst_fetcher dut (
      .clk_in              (clk_in),
      .rst_in              (rst_in),
      .rdy_in              (rdy_in),
      .IFIC_en             (IFIC_en),
      .IFIC_addr           (IFIC_addr),
      .ICIF_en             (ICIF_en),
      .ICIF_inst           (ICIF_inst),
      .IFDC_en             (IFDC_en),
      .IFDC_pc             (IFDC_pc),
      .IFDC_opcode         (IFDC_opcode),
      .IFDC_remain_inst    (IFDC_remain_inst),
      .IFDC_predict_result (IFDC_predict_result),
      .DCIF_ask_IF         (DCIF_ask_IF),
      .ROBIF_flush         (ROBIF_flush),
      .ROBIF_new_pc        (ROBIF_new_pc),
      .ROBIF_jalr_en       (ROBIF_jalr_en),
      .ROBIF_jalr_pc       (ROBIF_jalr_pc),
      .ROBIF_br_en         (ROBIF_br_en),
      .ROBIF_br_pc         (ROBIF_br_pc),
      .ROBIF_br_taken      (ROBIF_br_taken)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
      int          lat;
      logic [6:0]  opc;
      logic [24:0] remain;
      logic        pred;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Wait (bounded) for a fetch request and check its address
   task automatic wait_req(input string name, input logic [31:0] exp);
      int n = 0;
      while (!IFIC_en && n < 20) begin
         tick();
         n++;
      end
      if (!IFIC_en) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: no IFIC_en within 20 cycles, expected addr %h", name, exp);
      end else begin
         check(name, IFIC_addr, exp);
      end
   endtask

   // Return an icache word L cycles after the request was seen
   task automatic respond(input logic [31:0] inst, input int lat);
      for (int i = 1; i < lat; i++) tick();
      ICIF_en   = 1'b1;
      ICIF_inst = inst;
      tick();
      ICIF_en   = 1'b0;
   endtask

   initial begin
      logic [31:0] p_after_beq;
      logic        pred_beq;
      int          cnt;
      int          cnt2;

      //           addr      inst          lat opc     remain      pred
      vecs[0] = '{32'h00, 32'h00100093, 1, 7'h13, 25'h0002001, 1'b0};
      vecs[1] = '{32'h04, 32'h00000013, 2, 7'h13, 25'h0000000, 1'b0};
      vecs[2] = '{32'h08, 32'h010000EF, 2, 7'h6F, 25'h0020001, 1'b1};
      vecs[3] = '{32'h18, 32'h0080006F, 1, 7'h6F, 25'h0010000, 1'b1};
      vecs[4] = '{32'h20, 32'hFE000CE3, 3, 7'h63, 25'h1FC0019, 1'b0};
      vecs[5] = '{32'h24, 32'h00002103, 1, 7'h03, 25'h0000042, 1'b0};
      vecs[6] = '{32'h28, 32'h00209463, 2, 7'h63, 25'h0004128, 1'b0};

`ifdef IF_BHT_EN
      pred_beq    = 1'b1;
      p_after_beq = 32'h18;
`else
      pred_beq    = 1'b0;
      p_after_beq = 32'h24;
`endif

      rst_in = 1'b1; rdy_in = 1'b1; ICIF_en = 1'b0; ICIF_inst = '0;
      DCIF_ask_IF = 1'b1; ROBIF_flush = 1'b0; ROBIF_new_pc = '0;
      ROBIF_jalr_en = 1'b0; ROBIF_jalr_pc = '0;
      ROBIF_br_en = 1'b0; ROBIF_br_pc = '0; ROBIF_br_taken = 1'b0;
      tick(); tick();

      check("rst_ific_en",   32'(IFIC_en), 32'h0);
      check("rst_ific_addr", IFIC_addr, 32'h0);
      check("rst_ifdc_en",   32'(IFDC_en), 32'h0);
      check("rst_ifdc_pc",   IFDC_pc, 32'h0);
      check("rst_ifdc_op",   32'(IFDC_opcode), 32'h0);
      check("rst_ifdc_rem",  32'(IFDC_remain_inst), 32'h0);
      check("rst_ifdc_pred", 32'(IFDC_predict_result), 32'h0);
      rst_in = 1'b0;

      // Straight-line program through the table
      for (int i = 0; i < 7; i++) begin
         wait_req($sformatf("vec%0d_addr", i), vecs[i].addr);
         respond(vecs[i].inst, vecs[i].lat);
         check($sformatf("vec%0d_en", i),     32'(IFDC_en), 32'h1);
         check($sformatf("vec%0d_pc", i),     IFDC_pc, vecs[i].addr);
         check($sformatf("vec%0d_op", i),     32'(IFDC_opcode), 32'(vecs[i].opc));
         check($sformatf("vec%0d_rem", i),    32'(IFDC_remain_inst), 32'(vecs[i].remain));
         check($sformatf("vec%0d_pred", i),   32'(IFDC_predict_result), 32'(vecs[i].pred));
         tick();
         check($sformatf("vec%0d_pulse", i),  32'(IFDC_en), 32'h0);
         check($sformatf("vec%0d_hold", i),   IFDC_pc, vecs[i].addr);
      end

      // Train the counter at 0x20 twice, flush back to 0x20 while a request is in flight
      wait_req("train_addr", 32'h2C);
      ROBIF_br_en = 1'b1; ROBIF_br_pc = 32'h20; ROBIF_br_taken = 1'b1;
      tick(); tick();
      ROBIF_br_en = 1'b0;
      ROBIF_flush = 1'b1; ROBIF_new_pc = 32'h20;
      tick();
      ROBIF_flush = 1'b0;
      respond(32'h00000013, 1);
      check("discard_drop", 32'(IFDC_en), 32'h0);
      wait_req("refetch_beq", 32'h20);
      respond(32'hFE000CE3, 1);
      check("beq_en",   32'(IFDC_en), 32'h1);
      check("beq_pred", 32'(IFDC_predict_result), 32'(pred_beq));
      wait_req("beq_next", p_after_beq);

      // jalr stalls until the target is resolved
      respond(32'h00008067, 1);
      check("jalr_op",   32'(IFDC_opcode), 32'h67);
      check("jalr_pred", 32'(IFDC_predict_result), 32'h0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (IFIC_en) cnt++;
      end
      check("jalr_stall", 32'(cnt), 32'h0);
      ROBIF_jalr_en = 1'b1; ROBIF_jalr_pc = 32'h100;
      tick();
      ROBIF_jalr_en = 1'b0;
      wait_req("jalr_target", 32'h100);

      // Flush one cycle after the request, response two cycles later
      cnt = 0;
      tick();
      ROBIF_flush = 1'b1; ROBIF_new_pc = 32'h200;
      tick();
      if (IFDC_en) cnt++;
      ROBIF_flush = 1'b0;
      tick();
      if (IFDC_en) cnt++;
      respond(32'h00000013, 1);
      if (IFDC_en) cnt++;
      check("flushA_no_ifdc", 32'(cnt), 32'h0);
      wait_req("flushA_addr", 32'h200);

      // Flush and response in the same cycle
      ROBIF_flush = 1'b1; ROBIF_new_pc = 32'h300;
      ICIF_en = 1'b1; ICIF_inst = 32'h00000013;
      tick();
      ROBIF_flush = 1'b0; ICIF_en = 1'b0;
      check("flushB_no_ifdc", 32'(IFDC_en), 32'h0);
      wait_req("flushB_addr", 32'h300);
      respond(32'h00000013, 1);
      check("flushB_pc", IFDC_pc, 32'h300);

      // Decoder back-pressure
      DCIF_ask_IF = 1'b0;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (IFIC_en) cnt++;
      end
      check("ask_low_no_req", 32'(cnt), 32'h0);
      DCIF_ask_IF = 1'b1;
      wait_req("ask_resume", 32'h304);

      // Global pause during WAIT_MEM ignores even a flush
      rdy_in = 1'b0;
      ROBIF_flush = 1'b1; ROBIF_new_pc = 32'h400;
      cnt = 0; cnt2 = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (IFIC_en) cnt++;
         if (IFDC_en) cnt2++;
      end
      check("rdy_no_ific", 32'(cnt), 32'h0);
      check("rdy_no_ifdc", 32'(cnt2), 32'h0);
      check("rdy_addr",    IFIC_addr, 32'h304);
      check("rdy_ifdc_pc", IFDC_pc, 32'h300);
      rdy_in = 1'b1; ROBIF_flush = 1'b0;
      respond(32'h00100093, 1);
      check("rdy_resume_en", 32'(IFDC_en), 32'h1);
      check("rdy_resume_pc", IFDC_pc, 32'h304);
      wait_req("rdy_next", 32'h308);

      // Reset while a request is outstanding
      rst_in = 1'b1;
      tick();
      check("rst2_addr",  IFIC_addr, 32'h0);
      check("rst2_ifdc",  IFDC_pc, 32'h0);
      rst_in = 1'b0;
      wait_req("rst2_refetch", 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Instruction fetch stage of the out-of-order RV32I core. It sits directly upstream of the decoder and owns the architectural fetch PC. It requests instruction words from the instruction cache and predicts conditional branches with a 2-bit bimodal table. It hands one raw instruction at a time to the decoder, split into `opcode` and `remain_inst`, plus the predicted direction. It redirects on ROB flush and stalls on `jalr` until the target is resolved.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: PC and address width.
- `BHT_SIZE_LOG`, default 6: log2 of the number of predictor entries.
- `RESET_PC`, default 32'h0: fetch address after reset.

Ports:
- `clk_in`, in, 1: the single clock.
- `rst_in`, in, 1: reset, synchronous, active-high.
- `rdy_in`, in, 1: global pause. Low freezes all state.
- `IFIC_en`, out, 1: fetch request pulse to the icache.
- `IFIC_addr`, out, ADDR_WIDTH: fetch address.
- `ICIF_en`, in, 1: icache response valid, 1-cycle pulse.
- `ICIF_inst`, in, 32: instruction word.
- `IFDC_en`, out, 1: instruction valid to the decoder, 1-cycle pulse.
- `IFDC_pc`, out, ADDR_WIDTH: PC of the instruction.
- `IFDC_opcode`, out, 7: `inst[6:0]`.
- `IFDC_remain_inst`, out, 25: `inst[31:7]`.
- `IFDC_predict_result`, out, 1: 1 = predicted taken.
- `DCIF_ask_IF`, in, 1: downstream can accept one instruction.
- `ROBIF_flush`, in, 1: mispredict/redirect.
- `ROBIF_new_pc`, in, ADDR_WIDTH: redirect target.
- `ROBIF_jalr_en`, in, 1: jalr target resolved.
- `ROBIF_jalr_pc`, in, ADDR_WIDTH: jalr target.
- `ROBIF_br_en`, in, 1: branch commit, trains the predictor.
- `ROBIF_br_pc`, in, ADDR_WIDTH: PC of the committed branch.
- `ROBIF_br_taken`, in, 1: actual direction of the committed branch.

## Operation
- States: FETCH, WAIT_MEM, STALL_JALR, DISCARD.
- FETCH, with `DCIF_ask_IF`=1: pulse `IFIC_en` with `IFIC_addr`=pc and go to WAIT_MEM. With `DCIF_ask_IF`=0: stay in FETCH.
- WAIT_MEM, on `ICIF_en`: latch the instruction, pulse `IFDC_en`, and update pc by instruction type (all arithmetic mod 2^32):
  - `jal`: pc+immJ, `predict_result`=1.
  - branch (opcode 1100011): predicted taken (counter[1]) gives pc+immB, otherwise pc+4. `predict_result`=counter[1].
  - `jalr`: pc unchanged, `predict_result`=0, go to STALL_JALR.
  - all others: pc+4, `predict_result`=0.
  - Next state is FETCH except for `jalr`.
- STALL_JALR: on `ROBIF_jalr_en`, pc←`ROBIF_jalr_pc` and go to FETCH.
- Flush (highest priority, any state): pc←`ROBIF_new_pc`; no `IFDC_en` for the in-flight word.
  - In WAIT_MEM without a same-cycle `ICIF_en`: go to DISCARD, drop the next `ICIF_en`, then go to FETCH.
  - Flush and `ICIF_en` in the same cycle: drop the word and go to FETCH.
  - Flush in DISCARD: update pc and stay in DISCARD.
- Predictor:
  - 2^BHT_SIZE_LOG 2-bit counters indexed by `pc[BHT_SIZE_LOG+1:2]`; all reset to 2'b01.
  - On `ROBIF_br_en`, the counter at `ROBIF_br_pc` saturates up on taken and down on not-taken.
  - A same-cycle lookup and update of the same index reads the pre-update value.
- `rdy_in`=0: no state change, `IFIC_en`=0, `IFDC_en`=0.
- Reset values:
  - pc=`RESET_PC`, state FETCH.
  - `IFIC_en`=0, `IFIC_addr`=`RESET_PC`.
  - `IFDC_en`=0; `IFDC_pc`, `IFDC_opcode`, `IFDC_remain_inst`, `IFDC_predict_result` all 0.
  - Reset mid-WAIT_MEM abandons the request; the icache is reset in the same cycle.

## Timing
- All outputs are registered.
- `IFIC_en` at cycle t means the FETCH decision was made in cycle t-1.
- `ICIF_en` arrives at t+L, L≥1. `IFDC_en` arrives at t+L+1. The next `IFIC_en` comes no earlier than t+L+2.
- At most one outstanding icache request.
- `IFDC_*` fields hold their values after the pulse, until the next `IFDC_en`.

## Configuration
- `IF_BHT_EN` defined: bimodal predictor as specified above.
- `IF_BHT_EN` undefined:
  - No table is instantiated.
  - Branches are always predicted not-taken (pc+4, `predict_result`=0).
  - `ROBIF_br_*` inputs are ignored.
  - `jal` behaviour is unchanged.

## Structure
- Shared package holds:
  - RV32I major opcode constants (`jal` 1101111, `jalr` 1100111, branch 1100011).
  - The fetch state enum.
  - Immediate-extraction functions for immJ and immB.
- Sub-module `branch_predictor`: lookup port plus update port. Instantiated only under `IF_BHT_EN`.

## Test plan
- Reset, then return `ICIF_inst`=32'h00100093 for `IFIC_addr`=0 → `IFDC_en` pulse, `IFDC_pc`=0, `IFDC_opcode`=7'h13, `IFDC_remain_inst`=inst[31:7], `predict_result`=0; next `IFIC_addr`=4.
- `jal x1,16` (32'h010000EF) at pc 8 → `predict_result`=1, next `IFIC_addr`=32'h18.
- `beq x0,x0,-8` (32'hFE000CE3) at pc 32'h20 → predicted not-taken, next addr 32'h24. Then apply two `ROBIF_br_en` taken updates at pc 32'h20 and flush to 32'h20 → `predict_result`=1, next addr 32'h18. Without `IF_BHT_EN`, the same stimulus still gives 32'h24.
- `jalr x0,0(x1)` (32'h00008067) → no `IFIC_en` for 10 cycles; `ROBIF_jalr_en` with target 32'h100 → next `IFIC_addr`=32'h100.
- `ROBIF_flush` to 32'h200 one cycle after `IFIC_en`, with `ICIF_en` two cycles later → no `IFDC_en`, next `IFIC_addr`=32'h200. Repeat with flush and `ICIF_en` in the same cycle → same result.
- `DCIF_ask_IF`=0 for 5 cycles → no `IFIC_en`. `rdy_in`=0 during WAIT_MEM → state and outputs frozen until `rdy_in` returns high.
